sap_control_sequencer: RTL
==========================

// Module: sap_control_sequencer
// PURPOSE
//  Microcoded control sequencer for the 8-bit SAP datapath (PC, MAR, RAM, IR, A register, B register, ALU, OUT).
//  Steps fetch/execute T-states and decodes the IR opcode into one-hot register enables each cycle.
//  Drives the A register's load/send pins directly (a_load, a_send).
//  Supports free-run and single-step operation, and counts retired instructions.
// PARAMETERS
//  OPW          4  opcode width (IR upper nibble)
//  SHORT_CYCLE  0  1: instructions with no T5/T6 work (OUT, NOP) return to T1 after T4
//  ICNT_W       8  width of retired-instruction counter
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       async active-low reset
//  run          in   1       start execution; sampled only in IDLE
//  step_en      in   1       1: single-step mode; T-state advances only on cycles with step=1
//  step         in   1       single-step advance strobe (level, sampled per clk)
//  opcode       in   OPW     IR[7:4] from instruction register
//  pc_out       out  1       PC drives bus
//  pc_inc       out  1       PC increment
//  mar_load     out  1       MAR load from bus
//  ram_out      out  1       RAM drives bus
//  ir_load      out  1       IR load from bus
//  ir_out       out  1       IR[3:0] (operand address) drives bus
//  a_load       out  1       A register load
//  a_send       out  1       A register drives bus
//  b_load       out  1       B register load
//  alu_sub      out  1       ALU subtract (0 = add)
//  alu_out      out  1       ALU drives bus
//  out_load     out  1       output register load
//  halted       out  1       HLT executed
//  tstate       out  3       current T-state (0=IDLE/HALT, 1..6)
//  icount       out  ICNT_W  retired instructions
// BEHAVIOUR
//  - State register (IDLE,T1..T6,HALT) is async-cleared to IDLE; icount=0. All outputs are 0 in IDLE and HALT.
//  - Control outputs are combinational from registered state + opcode: zero latency within the T-state.
//  - IDLE -> T1 on a cycle with run=1. HALT is left only by reset_n.
//  - Advance condition adv = !step_en | step. Without adv, the state holds and its control word is reasserted.
//  - Advance order: T1->T2->...->T6->T1.
//  - Opcodes: LDA=0x0, ADD=0x1, SUB=0x2, OUT=0xE, HLT=0xF; any other value = NOP.
//  - Fetch: T1 pc_out,mar_load | T2 pc_inc | T3 ram_out,ir_load.
//  - LDA:     T4 ir_out,mar_load | T5 ram_out,a_load | T6 none.
//  - ADD/SUB: T4 ir_out,mar_load | T5 ram_out,b_load | T6 alu_out,a_load (+alu_sub for SUB).
//  - OUT:     T4 a_send,out_load | T5/T6 none.
//  - HLT:     T4 no enables; next state HALT on adv; halted=1 from the HALT cycle on.
//  - SHORT_CYCLE=1: OUT/NOP go T4->T1 on adv.
//  - icount increments (wraps at 2^ICNT_W) on the final T-state's adv of each LDA/ADD/SUB/OUT/NOP; HLT never counts.
//  - At most one bus driver (pc_out, ram_out, ir_out, a_send, alu_out) is active per cycle; this is an invariant.
//  - opcode is used only in T4..T6. Changes of opcode during T1..T3 have no effect.
//  - reset_n low mid-instruction: immediate return to IDLE and all enables drop asynchronously.
//  - step_en toggled mid-instruction: takes effect from the next cycle; the T-state is never skipped or repeated.
// STRUCTURE
//  - sap_ctrl_pkg: opcode localparams, state enum, ctrl_word_t packed struct (12 enables) with a CW_NONE constant.
//  - Sub-module sap_tstate_counter: IDLE/T1..T6/HALT register with run/adv/halt/short inputs.
//  - Top level: decode (case on state, opcode -> ctrl_word_t) and icount.
// TESTING
//  1. Reset, run=1 pulse, opcode=0x0 -> T1 pc_out+mar_load, T2 pc_inc, T3 ram_out+ir_load, T4 ir_out+mar_load,
//     T5 ram_out+a_load; icount=1 after T6.
//  2. opcode=0x2 free-run -> T5 b_load, T6 alu_out+alu_sub+a_load; ADD (0x1) gives the same T6 with alu_sub=0.
//  3. opcode=0xE, SHORT_CYCLE=1 -> T4 a_send+out_load, next state T1, icount+1;
//     SHORT_CYCLE=0 -> passes through T5/T6 with no enables.
//  4. opcode=0xF -> HALT after T4; halted=1 with all enables 0 for 20 cycles despite run/step; reset_n clears.
//  5. step_en=1, step pulsed every 4th cycle -> tstate changes only the cycle after each pulse;
//     control word is held in between.
//  6. reset_n=0 during T5 of ADD -> b_load drops immediately, tstate=0, icount=0.
//     Bench checks one-hot bus driver on every cycle, and icount wraps 255->0.

Source files
------------

// File: rtl/sap_ctrl_pkg.sv
// Shared opcode values, sequencer state encoding and the control-word layout
// for the SAP control sequencer.
package sap_ctrl_pkg;

    localparam int OP_LDA = 'h0;
    localparam int OP_ADD = 'h1;
    localparam int OP_SUB = 'h2;
    localparam int OP_OUT = 'hE;
    localparam int OP_HLT = 'hF;

    // Encoding chosen so T1..T6 map straight onto the tstate output value.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    typedef struct packed {
        logic pcOut;
        logic pcInc;
        logic marLoad;
        logic ramOut;
        logic irLoad;
        logic irOut;
        logic aLoad;
        logic aSend;
        logic bLoad;
        logic aluSub;
        logic aluOut;
        logic outLoad;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NONE = '0;

    function automatic logic [2:0] tstateOf(state_t s);
        return (s == ST_IDLE || s == ST_HALT) ? 3'd0 : 3'(s);
    endfunction

endpackage

// File: rtl/sap_tstate_counter.sv
// T-state register: IDLE -> T1..T6 ring, with an early T4 exit for short
// instructions and a terminal HALT state that only reset leaves.
module sap_tstate_counter
    import sap_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   run,
    input  logic   adv,
    input  logic   isHalt,
    input  logic   isShort,
    output state_t state
);

    state_t nextState;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= nextState;
    end

    always_comb begin
        // NOTE: defaulting nextState to state first covers every path and avoids an inferred latch.
        nextState = state;
        case (state)
            ST_IDLE: if (run) nextState = ST_T1;
            ST_T1:   if (adv) nextState = ST_T2;
            ST_T2:   if (adv) nextState = ST_T3;
            ST_T3:   if (adv) nextState = ST_T4;
            ST_T4: begin
                if (adv) begin
                    if (isHalt)       nextState = ST_HALT;
                    else if (isShort) nextState = ST_T1;
                    else              nextState = ST_T5;
                end
            end
            ST_T5:   if (adv) nextState = ST_T6;
            ST_T6:   if (adv) nextState = ST_T1;
            ST_HALT: nextState = ST_HALT;
            default: nextState = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP microcoded control sequencer: decodes T-state plus opcode into one-hot
// register enables and counts retired instructions.
module sap_control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int SHORT_CYCLE = 0,
    parameter int ICNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              step_en,
    input  logic              step,
    input  logic [OPW-1:0]    opcode,
    output logic              pc_out,
    output logic              pc_inc,
    output logic              mar_load,
    output logic              ram_out,
    output logic              ir_load,
    output logic              ir_out,
    output logic              a_load,
    output logic              a_send,
    output logic              b_load,
    output logic              alu_sub,
    output logic              alu_out,
    output logic              out_load,
    output logic              halted,
    output logic [2:0]        tstate,
    output logic [ICNT_W-1:0] icount
);

    localparam logic [OPW-1:0] OPC_LDA = OPW'(OP_LDA);
    localparam logic [OPW-1:0] OPC_ADD = OPW'(OP_ADD);
    localparam logic [OPW-1:0] OPC_SUB = OPW'(OP_SUB);
    localparam logic [OPW-1:0] OPC_OUT = OPW'(OP_OUT);
    localparam logic [OPW-1:0] OPC_HLT = OPW'(OP_HLT);

    state_t     state;
    ctrl_word_t cw;
    logic       adv;
    logic       isLda, isAdd, isSub, isOut, isHlt, isNop;
    logic       isShort;
    logic       retire;

    assign adv     = !step_en || step;
    assign isLda   = (opcode == OPC_LDA);
    assign isAdd   = (opcode == OPC_ADD);
    assign isSub   = (opcode == OPC_SUB);
    assign isOut   = (opcode == OPC_OUT);
    assign isHlt   = (opcode == OPC_HLT);
    assign isNop   = !(isLda || isAdd || isSub || isOut || isHlt);
    assign isShort = (SHORT_CYCLE != 0) && (isOut || isNop);

    sap_tstate_counter uCounter (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .adv     (adv),
        .isHalt  (isHlt),
        .isShort (isShort),
        .state   (state)
    );

    // Fetch is opcode-independent; opcode only steers T4..T6.
    always_comb begin
        cw = CW_NONE;
        case (state)
            ST_T1: begin cw.pcOut = 1'b1; cw.marLoad = 1'b1; end
            ST_T2: cw.pcInc = 1'b1;
            ST_T3: begin cw.ramOut = 1'b1; cw.irLoad = 1'b1; end
            ST_T4: begin
                if (isLda || isAdd || isSub) begin
                    cw.irOut   = 1'b1;
                    cw.marLoad = 1'b1;
                end else if (isOut) begin
                    cw.aSend   = 1'b1;
                    cw.outLoad = 1'b1;
                end
            end
            ST_T5: begin
                if (isLda) begin
                    cw.ramOut = 1'b1;
                    cw.aLoad  = 1'b1;
                end else if (isAdd || isSub) begin
                    cw.ramOut = 1'b1;
                    cw.bLoad  = 1'b1;
                end
            end
            ST_T6: begin
                if (isAdd || isSub) begin
                    cw.aluOut = 1'b1;
                    cw.aLoad  = 1'b1;
                    cw.aluSub = isSub;
                end
            end
            default: cw = CW_NONE;
        endcase
    end

    // An instruction retires on the advance out of its last T-state; HLT never retires.
    assign retire = adv && (((state == ST_T6) && !isHlt) || ((state == ST_T4) && isShort));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    icount <= '0;
        else if (retire) icount <= icount + ICNT_W'(1);
    end

    assign pc_out   = cw.pcOut;
    assign pc_inc   = cw.pcInc;
    assign mar_load = cw.marLoad;
    assign ram_out  = cw.ramOut;
    assign ir_load  = cw.irLoad;
    assign ir_out   = cw.irOut;
    assign a_load   = cw.aLoad;
    assign a_send   = cw.aSend;
    assign b_load   = cw.bLoad;
    assign alu_sub  = cw.aluSub;
    assign alu_out  = cw.aluOut;
    assign out_load = cw.outLoad;
    assign halted   = (state == ST_HALT);
    assign tstate   = tstateOf(state);

endmodule
